// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding, size codes, timeout default and alignment helper
package mem_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  localparam logic [1:0] SZ_NONE = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;
  localparam int TIMEOUT_DEF = 15;
  function automatic logic misaligned(logic [1:0] size, logic [1:0] lsb);
    return (size == SZ_HALF && lsb[0]) || (size == SZ_WORD && lsb != 2'b00);
  endfunction
endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rr_picker: two-way round-robin pick; on a tie the requester not granted last wins
module rr_picker (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] win
);
  assign win = (req == 2'b11) ? (last_owner ? 2'b01 : 2'b10) : (req[0] ? 2'b01 : (req[1] ? 2'b10 : 2'b00));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester memory arbiter with wait-state timeout and alignment checking
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [31:0] r_addr0,
  input  logic [31:0] r_addr1,
  input  logic [31:0] r_wdata0,
  input  logic [31:0] r_wdata1,
  input  logic [1:0]  r_rw,
  input  logic [1:0]  r_size0,
  input  logic [1:0]  r_size1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_rw,
  output logic [1:0]  mem_size,
  input  logic        mem_ready
);
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);
  state_t      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d, done_q, done_d, mem_size_q, mem_size_d;
  logic        err_q, err_d, mem_rw_q, mem_rw_d, last_owner_q, last_owner_d;
  logic [31:0] rdata_q, rdata_d, mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  win, sz;
  logic        sel, bad;
  logic [31:0] a, wd;

  rr_picker u_pick (.req(req), .last_owner(last_owner_q), .win(win));

  // next-state and registered-output computation for the access FSM
  always_comb begin
    sel = win[1];
    a = sel ? r_addr1 : r_addr0;
    wd = sel ? r_wdata1 : r_wdata0;
    sz = sel ? r_size1 : r_size0;
    bad = misaligned(sz, a[1:0]);
    state_d = state_q;
    gnt_d = gnt_q;
    done_d = 2'b00;
    err_d = 1'b0;
    rdata_d = rdata_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rw_d = 1'b0;
    mem_size_d = SZ_NONE;
    cnt_d = cnt_q;
    last_owner_d = last_owner_q;
    case (state_q)
      S_IDLE: if (|win) begin
        gnt_d = win;
        mem_addr_d = a;
        mem_wdata_d = wd;
        cnt_d = 4'd0;
        if (sz == SZ_NONE || bad) begin
          state_d = S_DONE;
          done_d = win;
          err_d = bad;
          rdata_d = 32'd0;
        end else begin
          state_d = S_ACCESS;
          mem_size_d = sz;
          mem_rw_d = r_rw[sel];
        end
      end
      S_ACCESS: if (mem_ready) begin
        state_d = S_DONE;
        done_d = gnt_q;
        rdata_d = mem_rw_q ? 32'd0 : mem_rdata;
      end else if (cnt_q == TO_LAST) begin
        state_d = S_DONE;
        done_d = gnt_q;
        err_d = 1'b1;
        rdata_d = 32'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
        mem_size_d = mem_size_q;
        mem_rw_d = mem_rw_q;
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d = 2'b00;
        last_owner_d = gnt_q[1];
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q <= 2'b00;
      done_q <= 2'b00;
      err_q <= 1'b0;
      rdata_q <= 32'd0;
      mem_addr_q <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_rw_q <= 1'b0;
      mem_size_q <= SZ_NONE;
      cnt_q <= 4'd0;
      last_owner_q <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rw_q <= mem_rw_d;
      mem_size_q <= mem_size_d;
      cnt_q <= cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign gnt = gnt_q;
  assign done = done_q;
  assign err = err_q;
  assign rdata = rdata_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rw = mem_rw_q;
  assign mem_size = mem_size_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard check of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int TIMEOUT = 15;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] req = 2'b00, r_rw = 2'b00, r_size0 = 2'd0, r_size1 = 2'd0;
  logic [31:0] r_addr0 = 32'd0, r_addr1 = 32'd0, r_wdata0 = 32'd0, r_wdata1 = 32'd0;
  logic [31:0] mem_rdata = 32'd0;
  logic mem_ready = 1'b0;
  logic [1:0] gnt, done, mem_size;
  logic err, mem_rw;
  logic [31:0] rdata, mem_addr, mem_wdata;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .r_addr0(r_addr0), .r_addr1(r_addr1),
    .r_wdata0(r_wdata0), .r_wdata1(r_wdata1), .r_rw(r_rw), .r_size0(r_size0), .r_size1(r_size1),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rw(mem_rw), .mem_size(mem_size), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  who;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t q[$];

  int total = 0, bad = 0, cyc = 0, waited = 0, ndone = 0;
  logic busy = 1'b0, fin = 1'b0, just_rst = 1'b1, last = 1'b1, owner = 1'b0;
  logic m_rw = 1'b0;
  logic [1:0] m_size = 2'd0;
  logic [31:0] m_addr = 32'd0, m_wdata = 32'd0;

  function automatic logic [1:0] ohot(logic o);
    return o ? 2'b10 : 2'b01;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, act, expv);
    end
  endtask

  // reference model: one transfer at a time, tracked by how long it has waited
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      busy = 1'b0;
      fin = 1'b0;
      last = 1'b1;
      q.delete();
      just_rst = 1'b1;
    end else begin
      just_rst = 1'b0;
      if (fin) begin
        fin = 1'b0;
        last = owner;
      end else if (busy) begin
        waited++;
        if (mem_ready) begin
          q.push_back('{ohot(owner), 1'b0, m_rw ? 32'd0 : mem_rdata, cyc});
          busy = 1'b0;
          fin = 1'b1;
        end else if (waited == TIMEOUT) begin
          q.push_back('{ohot(owner), 1'b1, 32'd0, cyc});
          busy = 1'b0;
          fin = 1'b1;
        end
      end else if (req != 2'b00) begin
        owner = (req == 2'b11) ? !last : req[1];
        m_addr = owner ? r_addr1 : r_addr0;
        m_wdata = owner ? r_wdata1 : r_wdata0;
        m_size = owner ? r_size1 : r_size0;
        m_rw = r_rw[owner];
        if (m_size == 0 || (m_size == 2 && m_addr % 2 != 0) || (m_size == 3 && m_addr % 4 != 0)) begin
          q.push_back('{ohot(owner), m_size != 0, 32'd0, cyc});
          fin = 1'b1;
        end else begin
          busy = 1'b1;
          waited = 0;
        end
      end
    end
  end

  // monitor: per-cycle bus checks plus scoreboard pop on every done pulse
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (just_rst) begin
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mem_size", {30'd0, mem_size}, 32'd0);
        chk("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
      end else begin
        chk("gnt", {30'd0, gnt}, (busy || fin) ? {30'd0, ohot(owner)} : 32'd0);
        chk("mem_size", {30'd0, mem_size}, busy ? {30'd0, m_size} : 32'd0);
        chk("mem_rw", {31'd0, mem_rw}, busy ? {31'd0, m_rw} : 32'd0);
        if (busy) begin
          chk("mem_addr", mem_addr, m_addr);
          chk("mem_wdata", mem_wdata, m_wdata);
        end
      end
      if (done != 2'b00) begin
        ndone++;
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done at cycle %0d: got done=%b expected none", cyc, done);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done", {30'd0, done}, {30'd0, e.who});
          chk("err", {31'd0, err}, {31'd0, e.err});
          chk("rdata", rdata, e.rdata);
          chk("done_cycle", cyc, e.cyc);
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        total++;
        bad++;
        $display("FAIL missing_done at cycle %0d: got done=00 expected %b", cyc, q[0].who);
        void'(q.pop_front());
      end
    end
  end

  // randomized stimulus; mode picks the memory's stall behaviour
  initial begin
    int mode;
    logic [31:0] a;
    mode = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (i % 50 == 0) mode = $urandom_range(0, 3);
      rst = ($urandom_range(0, 299) != 0);
      req = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      r_addr0 = a;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      r_addr1 = a;
      r_wdata0 = $urandom;
      r_wdata1 = $urandom;
      r_rw = 2'($urandom_range(0, 3));
      r_size0 = 2'($urandom_range(0, 3));
      r_size1 = 2'($urandom_range(0, 3));
      mem_rdata = $urandom;
      mem_ready = (mode == 0) ? ($urandom_range(0, 9) != 0) :
                  (mode == 1) ? ($urandom_range(0, 2) == 0) :
                  (mode == 2) ? 1'b0 : (busy && waited == TIMEOUT - 1);
    end
    @(negedge clk);
    rst = 1'b1;
    req = 2'b00;
    mem_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    chk("dones_seen", {31'd0, ndone > 200}, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
